// File: rtl/z16_prog_loader.sv
// Z16 program loader: receives a framed little-endian byte stream
// (word count, data words, optional checksum byte) over a valid/ready
// handshake, writes the words into instruction memory and releases the
// Z16 core reset once the whole image has landed.
// Optional feature macro: Z16_LOADER_CSUM_EN (trailing 8-bit checksum byte).
module z16_prog_loader #(
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 256
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    input  logic              i_restart,
    output logic              o_imem_wen,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [15:0]       o_imem_wdata,
    output logic              o_cpu_rst,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
`ifdef Z16_LOADER_CSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          lo_byte_q, lo_byte_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef Z16_LOADER_CSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif
    logic                accept;
    logic [15:0]         len_rx;

    // Byte-ready decode: only the states that consume a stream byte are ready.
    always_comb begin
        o_rx_ready = 1'b0;
        case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI: o_rx_ready = 1'b1;
`ifdef Z16_LOADER_CSUM_EN
            S_CSUM:                                   o_rx_ready = 1'b1;
`endif
            default:                                  o_rx_ready = 1'b0;
        endcase
    end

    assign accept = i_rx_valid && o_rx_ready;
    assign len_rx = {i_rx_data, len_lo_q};

    // Next-state and registered-output computation for the frame parser.
    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        lo_byte_d = lo_byte_q;
        cnt_d     = cnt_q;
        wen_d     = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`ifdef Z16_LOADER_CSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    len_lo_d = i_rx_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = len_rx;
                    if (len_rx > MAX_N) begin
                        state_d = S_ERR;
                    end else if (len_rx == 16'd0) begin
`ifdef Z16_LOADER_CSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA_LO;
                    end
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    lo_byte_d = i_rx_data;
`ifdef Z16_LOADER_CSUM_EN
                    csum_d    = csum_q + i_rx_data;
`endif
                    state_d   = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    // Word complete: issue the write one cycle later at byte address 2*k.
                    wen_d   = 1'b1;
                    wdata_d = {i_rx_data, lo_byte_q};
                    addr_d  = ADDR_W'({cnt_q, 1'b0});
                    cnt_d   = cnt_q + 16'd1;
`ifdef Z16_LOADER_CSUM_EN
                    csum_d  = csum_q + i_rx_data;
`endif
                    if (cnt_q == len_q - 16'd1) begin
`ifdef Z16_LOADER_CSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA_LO;
                    end
                end
            end
`ifdef Z16_LOADER_CSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (i_rx_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (i_restart) begin
                    state_d = S_LEN_LO;
                    cnt_d   = 16'd0;
`ifdef Z16_LOADER_CSUM_EN
                    csum_d  = 8'd0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags follow the next state so they change on the same edge as the state.
    always_comb begin
        cpu_rst_d = (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
    end

    // State and output registers; async reset aborts any partial frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            len_lo_q  <= 8'd0;
            len_q     <= 16'd0;
            lo_byte_q <= 8'd0;
            cnt_q     <= 16'd0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 16'd0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef Z16_LOADER_CSUM_EN
            csum_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            len_q     <= len_d;
            lo_byte_q <= lo_byte_d;
            cnt_q     <= cnt_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef Z16_LOADER_CSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign o_imem_wen   = wen_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: doc/z16_prog_loader.md
Name: z16_prog_loader

Overview:
Byte-stream program loader that writes a Z16 program image into instruction memory and holds the Z16 core in reset until the image is in place. It receives a framed byte stream (length, little-endian words, optional checksum) over a valid/ready handshake and drives the instruction memory write port. It sits between the host link (UART receiver or testbench) and the instruction memory / CPU reset input.

Parameters:
ADDR_W, 16, width of instruction memory byte address
MAX_WORDS, 256, instruction memory capacity in 16-bit words; larger frames are rejected

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_rx_valid  input  1  byte available on i_rx_data
i_rx_data  input  8  received byte
o_rx_ready  output  1  loader accepts byte this cycle
i_restart  input  1  single-cycle pulse; restart loading from DONE or ERR
o_imem_wen  output  1  instruction memory write enable, one-cycle pulse
o_imem_addr  output  ADDR_W  instruction memory byte address (always even)
o_imem_wdata  output  16  instruction word to write
o_cpu_rst  output  1  active-high reset to the Z16 core
o_done  output  1  image loaded successfully (level)
o_err  output  1  frame rejected (level)

Behaviour:
- One clock, i_clk; reset is asynchronous and active-low on i_rst_n. All state and outputs are registered except o_rx_ready.
- Reset values: state IDLE, o_imem_wen 0, o_imem_addr 0, o_imem_wdata 0, o_cpu_rst 1, o_done 0, o_err 0, word counter 0, checksum 0.
- Accept = i_rx_valid && o_rx_ready. o_rx_ready is 1 exactly in LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM; 0 elsewhere. i_rx_data is ignored unless accepted.
- Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N words each as low byte then high byte, then (with checksum feature) one checksum byte.
- States/transitions:
  IDLE -> LEN_LO unconditionally one cycle after reset release.
  LEN_LO --accept--> LEN_HI (latch low byte).
  LEN_HI --accept--> if N > MAX_WORDS: ERR; if N == 0: CSUM (or DONE without feature); else DATA_LO.
  DATA_LO --accept--> DATA_HI (latch low byte).
  DATA_HI --accept--> write issued; if last word: CSUM (or DONE without feature); else DATA_LO.
  CSUM --accept--> DONE if byte matches, else ERR.
  DONE/ERR: hold; i_restart -> LEN_LO, clears o_done/o_err, resets counter and checksum, o_cpu_rst back to 1 that same edge.
- Write timing: on the edge that accepts the high byte of word k (k from 0), next cycle o_imem_wen=1, o_imem_wdata={hi,lo}, o_imem_addr=2*k (truncated to ADDR_W). o_imem_wen is 1 for exactly one cycle per word; o_imem_addr/o_imem_wdata hold their last values otherwise.
- Back-to-back bytes (valid held high) accepted every cycle; gaps in i_rx_valid stall without side effects.
- o_cpu_rst = 0 only while in DONE (registered; deasserts the cycle DONE is entered, at or after the final write pulse). ERR keeps o_cpu_rst=1.
- o_done=1 only in DONE; o_err=1 only in ERR; never both.
- i_restart outside DONE/ERR is ignored. Async reset mid-frame aborts immediately to reset values; partial words are not written.
- Checksum: 8-bit wrapping sum of all data bytes (length bytes excluded); cleared on restart/reset.

Optional Feature:
Z16_LOADER_CSUM_EN: defined -> CSUM state present, trailing checksum byte required and compared; mismatch -> ERR. Undefined -> no CSUM state, no checksum byte; last data word (or N==0) goes directly to DONE; ERR reachable only through oversize length.

Test Plan:
- Bytes 02 00 34 12 78 56 (+ checksum 0x14 with feature) -> wen pulses: addr 0x0000 data 0x1234, addr 0x0002 data 0x5678; o_done=1, o_cpu_rst=0.
- Length 0x0101 (257) with MAX_WORDS=256 -> ERR after second byte, no wen pulse, o_cpu_rst stays 1, o_rx_ready=0.
- With Z16_LOADER_CSUM_EN: frame 01 00 CD AB, checksum 0x00 -> o_err=1 (expected 0x78), wen still pulsed once at addr 0 with data 0xABCD.
- i_rx_valid toggled 1/0 every cycle during 3-word frame -> same writes as continuous stream, one wen per word, addresses 0,2,4.
- i_rst_n pulled low after LEN_HI and one data byte -> all outputs at reset values, o_cpu_rst=1; fresh frame afterwards loads from addr 0.
- In DONE, pulse i_restart, send 01 00 EF BE (+0xAD) -> o_cpu_rst reasserts same edge, write addr 0 data 0xBEEF, DONE again.
